// File: rtl/tour_cmd.sv
// Purpose : replays a solved knight's tour as drive commands, two per move (vertical leg, then horizontal leg).
// Latency : start_tour to first cmd_rdy is 2 cycles; each later command follows 2 cycles after the previous resp_rdy.
// Backpr. : cmd/cmd_rdy are held until clr_cmd_rdy; the next command is not built until resp_rdy reports completion.
//
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   start_tour    - pulse from the solver; accepted only in IDLE
//   move          - one-hot knight move for the current mv_indx (combinational from the solver)
//   mv_indx       - index of the move being replayed
//   cmd           - {opcode[15:12], heading[11:4], squares[3:0]}, registered
//   cmd_rdy       - cmd valid, held until clr_cmd_rdy
//   clr_cmd_rdy   - consumer has taken cmd
//   resp_rdy      - consumer finished executing the accepted command
//   tour_busy     - high while a tour is in progress
//   tour_done     - one-cycle pulse after the final response
//   tour_err      - sticky, set when a move is not one-hot; cleared by the next accepted start
module tour_cmd #(
   parameter int NUM_MOVES    = 24,
   parameter bit FANFARE_LAST = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_tour,
   input  logic [7:0]  move,
   output logic [4:0]  mv_indx,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic        resp_rdy,
   output logic        tour_busy,
   output logic        tour_done,
   output logic        tour_err
);

   typedef enum logic [2:0] {
      IDLE, LD_V, WT_CLR_V, WT_RSP_V, LD_H, WT_CLR_H, WT_RSP_H
   } state_t;

   localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);
   localparam logic [3:0] OP_V     = 4'h4;
   localparam logic [3:0] OP_H     = FANFARE_LAST ? 4'h5 : 4'h4;
   localparam logic [7:0] HD_POS_Y = 8'h00;
   localparam logic [7:0] HD_NEG_Y = 8'h7F;
   localparam logic [7:0] HD_NEG_X = 8'h3F;
   localparam logic [7:0] HD_POS_X = 8'hBF;

   state_t      state;
   state_t      nxt_state;

   logic        dy_pos;
   logic        dx_pos;
   logic [3:0]  dy_sq;
   logic [3:0]  dx_sq;
   logic        move_ok;
   logic [15:0] v_cmd;
   logic [15:0] h_cmd;

   logic        start_acc;
   logic        load_v;
   logic        load_h;
   logic        drop_rdy;
   logic        inc_idx;
   logic        done_set;
   logic        err_set;

   // Move decode. Only exact one-hot codes match a case item, so a zero
   // square count doubles as the "not one-hot" indication.
   always_comb begin
      dy_pos = 1'b1;
      dx_pos = 1'b1;
      dy_sq  = 4'd0;
      dx_sq  = 4'd0;
      case (move)
         8'h01: begin dx_pos = 1'b0; dx_sq = 4'd1; dy_pos = 1'b1; dy_sq = 4'd2; end
         8'h02: begin dx_pos = 1'b1; dx_sq = 4'd1; dy_pos = 1'b1; dy_sq = 4'd2; end
         8'h04: begin dx_pos = 1'b0; dx_sq = 4'd2; dy_pos = 1'b1; dy_sq = 4'd1; end
         8'h08: begin dx_pos = 1'b0; dx_sq = 4'd2; dy_pos = 1'b0; dy_sq = 4'd1; end
         8'h10: begin dx_pos = 1'b0; dx_sq = 4'd1; dy_pos = 1'b0; dy_sq = 4'd2; end
         8'h20: begin dx_pos = 1'b1; dx_sq = 4'd1; dy_pos = 1'b0; dy_sq = 4'd2; end
         8'h40: begin dx_pos = 1'b1; dx_sq = 4'd2; dy_pos = 1'b0; dy_sq = 4'd1; end
         8'h80: begin dx_pos = 1'b1; dx_sq = 4'd2; dy_pos = 1'b1; dy_sq = 4'd1; end
         default: ;
      endcase
   end

   assign move_ok = (dy_sq != 4'd0);
   assign v_cmd   = {OP_V, (dy_pos ? HD_POS_Y : HD_NEG_Y), dy_sq};
   assign h_cmd   = {OP_H, (dx_pos ? HD_POS_X : HD_NEG_X), dx_sq};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= nxt_state;
      end
   end

   // clr_cmd_rdy is only acted on in WT_CLR_x (where cmd_rdy is high) and
   // resp_rdy only in WT_RSP_x, so stray strobes elsewhere fall through.
   always_comb begin
      nxt_state = state;
      start_acc = 1'b0;
      load_v    = 1'b0;
      load_h    = 1'b0;
      drop_rdy  = 1'b0;
      inc_idx   = 1'b0;
      done_set  = 1'b0;
      err_set   = 1'b0;
      case (state)
         IDLE: begin
            if (start_tour) begin
               start_acc = 1'b1;
               nxt_state = LD_V;
            end
         end
         LD_V: begin
            if (move_ok) begin
               load_v    = 1'b1;
               nxt_state = WT_CLR_V;
            end else begin
               err_set   = 1'b1;
               nxt_state = IDLE;
            end
         end
         WT_CLR_V: begin
            if (clr_cmd_rdy) begin
               drop_rdy  = 1'b1;
               nxt_state = WT_RSP_V;
            end
         end
         WT_RSP_V: begin
            if (resp_rdy) begin
               nxt_state = LD_H;
            end
         end
         LD_H: begin
            load_h    = 1'b1;
            nxt_state = WT_CLR_H;
         end
         WT_CLR_H: begin
            if (clr_cmd_rdy) begin
               drop_rdy  = 1'b1;
               nxt_state = WT_RSP_H;
            end
         end
         WT_RSP_H: begin
            if (resp_rdy) begin
               if (mv_indx == LAST_IDX) begin
                  done_set  = 1'b1;
                  nxt_state = IDLE;
               end else begin
                  inc_idx   = 1'b1;
                  nxt_state = LD_V;
               end
            end
         end
         default: nxt_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mv_indx   <= 5'd0;
         cmd       <= 16'h0000;
         cmd_rdy   <= 1'b0;
         tour_done <= 1'b0;
         tour_err  <= 1'b0;
      end else begin
         tour_done <= done_set;

         // mv_indx is left untouched on return to IDLE so it keeps the last index.
         if (start_acc) begin
            mv_indx <= 5'd0;
         end else if (inc_idx) begin
            mv_indx <= mv_indx + 5'd1;
         end

         if (start_acc) begin
            tour_err <= 1'b0;
         end else if (err_set) begin
            tour_err <= 1'b1;
         end

         // cmd only changes in LD_x, i.e. never while cmd_rdy is high.
         if (load_v) begin
            cmd <= v_cmd;
         end else if (load_h) begin
            cmd <= h_cmd;
         end

         if (load_v || load_h) begin
            cmd_rdy <= 1'b1;
         end else if (drop_rdy) begin
            cmd_rdy <= 1'b0;
         end
      end
   end

   assign tour_busy = (state != IDLE);

endmodule

// File: tb/tb_tour_cmd.sv
// Purpose : randomized scoreboard bench for tour_cmd against a move-table reference model.
// Latency : n/a (bench).
// Backpr. : the bench acts as the consumer, with random clr/resp delays and stray strobes.
module tb_tour_cmd;

   localparam int NM = 24;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_tour;
   logic [7:0]  move;
   logic [4:0]  mv_indx;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy;
   logic        resp_rdy;
   logic        tour_busy;
   logic        tour_done;
   logic        tour_err;

   always #5 clk = ~clk;

   tour_cmd #(.NUM_MOVES(NM), .FANFARE_LAST(1'b1)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_tour  (start_tour),
      .move        (move),
      .mv_indx     (mv_indx),
      .cmd         (cmd),
      .cmd_rdy     (cmd_rdy),
      .clr_cmd_rdy (clr_cmd_rdy),
      .resp_rdy    (resp_rdy),
      .tour_busy   (tour_busy),
      .tour_done   (tour_done),
      .tour_err    (tour_err)
   );

   // The "solver": a table of moves looked up by the replayed index.
   logic [7:0] moves [32];
   assign move = moves[mv_indx];

   typedef struct packed {
      logic [4:0]  idx;
      logic [15:0] cmd;
   } exp_t;

   exp_t sb_q [$];
   exp_t mon_cur;
   bit   mon_have  = 1'b0;
   bit   mon_prev  = 1'b0;
   int   checks    = 0;
   int   errors    = 0;
   int   done_owed = 0;
   int   rdy_rises = 0;
   int   base      = 0;
   bit   ok;

   // Knight displacement table, indexed by the set bit of the move.
   int DX [8] = '{-1,  1, -2, -2, -1,  1,  2,  2};
   int DY [8] = '{ 2,  2,  1, -1, -2, -2, -1,  1};

   function automatic logic [15:0] ref_cmd(input logic [7:0] m, input bit horiz);
      int b = -1;
      int d;
      int mag;
      for (int i = 0; i < 8; i++) begin
         if (m == 8'(1 << i)) b = i;
      end
      if (b < 0) return 16'h0000;
      d   = horiz ? DX[b] : DY[b];
      mag = (d < 0) ? -d : d;
      if (!horiz) return {4'h4, ((d > 0) ? 8'h00 : 8'h7F), 4'(mag)};
      return {4'h5, ((d > 0) ? 8'hBF : 8'h3F), 4'(mag)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic chk_rst(input string tag);
      chk({tag, "_mv_indx"}, 32'(mv_indx),   32'h0);
      chk({tag, "_cmd"},     32'(cmd),       32'h0);
      chk({tag, "_cmd_rdy"}, 32'(cmd_rdy),   32'h0);
      chk({tag, "_busy"},    32'(tour_busy), 32'h0);
      chk({tag, "_done"},    32'(tour_done), 32'h0);
      chk({tag, "_err"},     32'(tour_err),  32'h0);
   endtask

   task automatic rand_moves();
      for (int i = 0; i < 32; i++) moves[i] = 8'(1 << $urandom_range(0, 7));
   endtask

   // Expected output of replaying the first n moves: a vertical then a horizontal command each.
   task automatic push_tour(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.idx = 5'(i);
         e.cmd = ref_cmd(moves[i], 1'b0);
         sb_q.push_back(e);
         e.cmd = ref_cmd(moves[i], 1'b1);
         sb_q.push_back(e);
      end
   endtask

   // All stimulus tasks start and end at posedge+1.
   task automatic do_start();
      start_tour = 1'b1;
      @(posedge clk); #1;
      start_tour = 1'b0;
      chk("start_busy",      32'(tour_busy), 32'h1);
      chk("start_err_clr",   32'(tour_err),  32'h0);
      chk("start_idx",       32'(mv_indx),   32'h0);
      chk("start_rdy_early", 32'(cmd_rdy),   32'h0);
      @(posedge clk); #1;
      chk("start_latency",   32'(cmd_rdy),   32'h1);
   endtask

   task automatic wait_rdy(output bit got);
      got = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (cmd_rdy) begin
            got = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      if (!got) chk("cmd_rdy_timeout", 32'(cmd_rdy), 32'h1);
   endtask

   // Accept the presented command, then report completion. With noise, stray
   // resp_rdy strobes appear while waiting to clear (and alongside the clear),
   // and stray clr_cmd_rdy strobes while the command executes.
   task automatic handshake(input bit rnd);
      int d1;
      int d2;
      d1 = rnd ? int'($urandom_range(0, 3)) : 0;
      d2 = rnd ? int'($urandom_range(0, 3)) : 0;
      for (int i = 0; i < d1; i++) begin
         resp_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
         @(posedge clk); #1;
      end
      resp_rdy    = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      clr_cmd_rdy = 1'b1;
      @(posedge clk); #1;
      clr_cmd_rdy = 1'b0;
      resp_rdy    = 1'b0;
      for (int i = 0; i < d2; i++) begin
         clr_cmd_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
         @(posedge clk); #1;
      end
      clr_cmd_rdy = 1'b0;
      resp_rdy    = 1'b1;
      @(posedge clk); #1;
      resp_rdy    = 1'b0;
   endtask

   task automatic finish_tour(input int from, input bit rnd, input int rises_base);
      bit got;
      for (int c = from; c < 2 * NM; c++) begin
         wait_rdy(got);
         if (!got) return;
         handshake(rnd);
      end
      chk("done_pulse",     32'(tour_done), 32'h1);
      chk("busy_after_end", 32'(tour_busy), 32'h0);
      chk("idx_at_end",     32'(mv_indx),   32'(NM - 1));
      @(posedge clk); #1;
      chk("done_one_cycle", 32'(tour_done), 32'h0);
      chk("idx_hold_idle",  32'(mv_indx),   32'(NM - 1));
      chk("cmd_count",      32'(rdy_rises - rises_base), 32'(2 * NM));
      chk("sb_drained",     32'(sb_q.size()), 32'h0);
      chk("done_seen",      32'(done_owed), 32'h0);
   endtask

   initial begin
      rst_n       = 1'b0;
      start_tour  = 1'b0;
      clr_cmd_rdy = 1'b0;
      resp_rdy    = 1'b0;
      for (int i = 0; i < 32; i++) moves[i] = 8'h01;
      fork
         begin : main_flow
            repeat (3) @(posedge clk);
            #1;
            chk_rst("reset");
            rst_n = 1'b1;
            @(posedge clk); #1;

            // Directed tour: known first moves, stray strobes while waiting to clear,
            // then single-cycle clear/response for the whole tour.
            rand_moves();
            moves[0] = 8'h01;
            moves[1] = 8'h40;
            push_tour(NM);
            done_owed++;
            base = rdy_rises;
            do_start();
            chk("first_cmd", 32'(cmd), 32'h4002);
            resp_rdy = 1'b1;
            @(posedge clk); #1;
            resp_rdy   = 1'b0;
            start_tour = 1'b1;
            @(posedge clk); #1;
            start_tour = 1'b0;
            chk("stray_rdy_hold", 32'(cmd_rdy), 32'h1);
            chk("stray_idx_hold", 32'(mv_indx), 32'h0);
            chk("stray_cmd_hold", 32'(cmd),     32'h4002);
            handshake(1'b0);
            wait_rdy(ok);
            chk("second_cmd", 32'(cmd), 32'h53F1);
            handshake(1'b0);
            wait_rdy(ok);
            chk("move40_v", 32'(cmd), 32'h47F1);
            handshake(1'b0);
            wait_rdy(ok);
            chk("move40_h", 32'(cmd), 32'h5BF2);
            finish_tour(3, 1'b0, base);

            // Random tours with random consumer timing and stray strobes.
            for (int t = 0; t < 3; t++) begin
               rand_moves();
               push_tour(NM);
               done_owed++;
               base = rdy_rises;
               do_start();
               finish_tour(0, 1'b1, base);
            end

            // Two bits set at index 5 aborts the tour after five good moves.
            rand_moves();
            moves[5] = 8'h03;
            push_tour(5);
            base = rdy_rises;
            do_start();
            for (int c = 0; c < 10; c++) begin
               wait_rdy(ok);
               if (!ok) break;
               handshake(1'b1);
            end
            for (int i = 0; i < 10 && tour_busy; i++) begin
               @(posedge clk); #1;
            end
            chk("err_busy_drop", 32'(tour_busy), 32'h0);
            chk("err_flag",      32'(tour_err),  32'h1);
            chk("err_no_rdy",    32'(cmd_rdy),   32'h0);
            chk("err_cmd_count", 32'(rdy_rises - base), 32'd10);
            repeat (3) @(posedge clk);
            #1;
            chk("err_sticky",    32'(tour_err),  32'h1);
            chk("err_idle_rdy",  32'(cmd_rdy),   32'h0);
            chk("err_sb_empty",  32'(sb_q.size()), 32'h0);
            moves[5] = 8'h80;
            push_tour(NM);
            done_owed++;
            base = rdy_rises;
            do_start();
            finish_tour(0, 1'b1, base);

            // Reset while waiting for the horizontal response of move 10.
            rand_moves();
            push_tour(NM);
            done_owed++;
            base = rdy_rises;
            do_start();
            for (int c = 0; c < 21; c++) begin
               wait_rdy(ok);
               if (!ok) break;
               handshake(1'b0);
            end
            wait_rdy(ok);
            chk("pre_rst_idx", 32'(mv_indx), 32'd10);
            chk("pre_rst_h",   32'(cmd),     32'(ref_cmd(moves[10], 1'b1)));
            clr_cmd_rdy = 1'b1;
            @(posedge clk); #1;
            clr_cmd_rdy = 1'b0;
            #2 rst_n = 1'b0;
            #1;
            chk_rst("async_rst");
            sb_q.delete();
            done_owed = 0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            chk("post_rst_busy", 32'(tour_busy), 32'h0);
            chk("post_rst_rdy",  32'(cmd_rdy),   32'h0);
            rand_moves();
            push_tour(NM);
            done_owed++;
            base = rdy_rises;
            do_start();
            chk("restart_idx", 32'(mv_indx), 32'h0);
            chk("restart_cmd", 32'(cmd),     32'(ref_cmd(moves[0], 1'b0)));
            finish_tour(0, 1'b1, base);

            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
         end
         begin : monitor
            forever begin
               @(negedge clk);
               if (!rst_n) begin
                  mon_prev = 1'b0;
                  mon_have = 1'b0;
               end else begin
                  if (cmd_rdy && !mon_prev) begin
                     rdy_rises++;
                     if (sb_q.size() == 0) begin
                        mon_have = 1'b0;
                        chk("unexpected_cmd", 32'(cmd_rdy), 32'h0);
                     end else begin
                        mon_cur  = sb_q.pop_front();
                        mon_have = 1'b1;
                        chk("cmd_idx", 32'(mv_indx), 32'(mon_cur.idx));
                     end
                  end
                  // Checked every cycle cmd_rdy is held, so it also covers stability.
                  if (cmd_rdy && mon_have) begin
                     chk("cmd_value", 32'(cmd), 32'(mon_cur.cmd));
                  end
                  if (tour_done) begin
                     if (done_owed == 0) begin
                        chk("unexpected_done", 32'(tour_done), 32'h0);
                     end else begin
                        done_owed--;
                        chk("done_after_last_cmd", 32'(sb_q.size()), 32'h0);
                     end
                  end
                  mon_prev = cmd_rdy;
               end
            end
         end
      join_any
   end

endmodule

// File: doc/tour_cmd.md
TOUR_CMD -- requirements
Module: tour_cmd

Interface
REQ-001 SHALL have parameter NUM_MOVES, default 24: number of moves replayed per tour.
REQ-002 SHALL have parameter FANFARE_LAST, default 1: when 1, every move's second command uses the fanfare opcode.
REQ-003 SHALL have port clk, input, 1: single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port start_tour, input, 1: one-cycle pulse from the tour solver's done; begins replay.
REQ-006 SHALL have port move, input, 8: one-hot knight move for mv_indx, combinational from the solver.
REQ-007 SHALL have port mv_indx, output, 5: index of the move being replayed.
REQ-008 SHALL have port cmd, output, 16: registered command {opcode[15:12], heading[11:4], squares[3:0]}.
REQ-009 SHALL have port cmd_rdy, output, 1: cmd valid; held until consumed.
REQ-010 SHALL have port clr_cmd_rdy, input, 1: consumer accepts cmd.
REQ-011 SHALL have port resp_rdy, input, 1: pulse when the accepted command has finished executing.
REQ-012 SHALL have port tour_busy, output, 1: high from the cycle after start_tour until return to IDLE.
REQ-013 SHALL have port tour_done, output, 1: one-cycle pulse when the last response arrives.
REQ-014 SHALL have port tour_err, output, 1: sticky; set on a non-one-hot move.

Function
REQ-015 SHALL implement states IDLE, LD_V, WT_CLR_V, WT_RSP_V, LD_H, WT_CLR_H, WT_RSP_H.
REQ-016 SHALL decode moves as (dx,dy): bit0(-1,+2) bit1(+1,+2) bit2(-2,+1) bit3(-2,-1) bit4(-1,-2) bit5(+1,-2) bit6(+2,-1) bit7(+2,+1).
REQ-017 SHALL issue the vertical (dy) command first, then the horizontal (dx) command, for every move.
REQ-018 SHALL set headings: +y 8'h00, -y 8'h7F, -x 8'h3F, +x 8'hBF; squares = |d| (1 or 2).
REQ-019 SHALL use opcode 4'h4 for the vertical command, and 4'h5 for the horizontal command when FANFARE_LAST=1, otherwise 4'h4.
REQ-020 SHALL, in IDLE on start_tour, clear mv_indx to 0 and go to LD_V; start_tour in any other state SHALL be ignored.
REQ-021 SHALL, in LD_V/LD_H, register cmd from the current move, set cmd_rdy next edge, and go to WT_CLR_V/WT_CLR_H; latency start_tour to cmd_rdy = 2 cycles.
REQ-022 SHALL, in WT_CLR_x on clr_cmd_rdy, clear cmd_rdy next edge and go to WT_RSP_x; cmd SHALL stay stable while cmd_rdy is high.
REQ-023 SHALL ignore clr_cmd_rdy when cmd_rdy is low, and ignore resp_rdy outside WT_RSP_x, including a resp_rdy coincident with clr_cmd_rdy.
REQ-024 SHALL, in WT_RSP_V on resp_rdy, go to LD_H.
REQ-025 SHALL, in WT_RSP_H on resp_rdy with mv_indx==NUM_MOVES-1, pulse tour_done and go to IDLE; otherwise increment mv_indx and go to LD_V.
REQ-026 SHALL never let mv_indx exceed NUM_MOVES-1; it SHALL hold its value in IDLE after a tour.
REQ-027 SHALL, in LD_V when move is not one-hot, set tour_err, assert neither cmd_rdy nor tour_done, and return to IDLE.
REQ-028 SHALL clear tour_err on the next accepted start_tour.

Reset
REQ-029 SHALL, on rst_n low at any time, go to IDLE and force mv_indx=0, cmd=16'h0000, cmd_rdy=0, tour_busy=0, tour_done=0, tour_err=0.
REQ-030 SHALL, on reset mid-tour, discard all progress; a fresh start_tour SHALL be required to resume.

Verification
REQ-031 SHALL verify: start_tour with move[0]=8'h01 -> cmd=16'h4002 with cmd_rdy 2 cycles later; after clr and resp -> cmd=16'h53F1.
REQ-032 SHALL verify: move=8'h40 -> vertical 16'h47F1, horizontal 16'h5BF2.
REQ-033 SHALL verify: a full 24-move tour with single-cycle clr/resp -> exactly 48 cmd_rdy assertions, mv_indx 0..23, and one tour_done pulse after the 48th resp_rdy.
REQ-034 SHALL verify: resp_rdy pulsed in WT_CLR_V and start_tour pulsed mid-tour -> no state change and no extra commands.
REQ-035 SHALL verify: move=8'h03 at mv_indx 5 -> tour_err=1, cmd_rdy stays 0, state returns to IDLE; next start_tour clears tour_err.
REQ-036 SHALL verify: rst_n asserted in WT_RSP_H at mv_indx 10 -> all outputs reach reset values asynchronously; start_tour then begins again at mv_indx 0.
